// File: rtl/j1_pkg.sv
// Shared J1 front-end types: fetch widths and the PC-tagged instruction entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package j1_pkg;

    localparam int J1_ADDR_WIDTH = 13;
    localparam int J1_DATA_WIDTH = 16;

    // One fetched word together with the address it came from; the decoder
    // consumes the same layout.
    typedef struct packed {
        logic [J1_ADDR_WIDTH-1:0] pc;
        logic [J1_DATA_WIDTH-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/j1_fetch_if.sv
// Fetch-stage bus: ROM read port, branch redirect and decoder handshake.
// Latency: n/a (wiring only).
// Backpressure: decoder holds insn_ready low to stall the fetch stage.
interface j1_fetch_if
    import j1_pkg::*;
#(
    parameter int ADDR_WIDTH = J1_ADDR_WIDTH,
    parameter int DATA_WIDTH = J1_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0] rom_address;
    logic                  rom_cen;
    logic [DATA_WIDTH-1:0] rom_q;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  insn_valid;
    logic                  insn_ready;
    logic [DATA_WIDTH-1:0] insn;
    logic [ADDR_WIDTH-1:0] insn_pc;

    // Fetch-stage side.
    modport master (
        output rom_address, rom_cen, insn_valid, insn, insn_pc,
        input  rom_q, redirect, redirect_pc, insn_ready
    );

    // ROM / decoder / branch-unit side.
    modport slave (
        input  rom_address, rom_cen, insn_valid, insn, insn_pc,
        output rom_q, redirect, redirect_pc, insn_ready
    );

endinterface

// File: rtl/j1_fetch_queue.sv
// Shift-register FIFO of fetch entries; head is always slot 0 (a plain flop).
// Latency: push visible at head the cycle after the push edge when empty.
// Backpressure: caller must not push when full without a same-cycle pop.
module fetch_queue
    import j1_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  fetch_entry_t               i_dat,
    output logic                       o_full,
    output logic                       o_empty,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic [IW-1:0] w_wr_idx;

    // A pop on an empty queue is ignored; a push into a full queue only
    // lands when the head leaves in the same cycle.
    assign w_pop    = i_pop & (r_count != '0);
    assign w_push   = i_push & ((r_count != CW'(DEPTH)) | w_pop);
    assign w_wr_idx = IW'(r_count - CW'(w_pop));

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[0];
    assign o_count  = r_count;

    // Storage and occupancy: clear wins, otherwise shift on pop and write
    // the new entry just above the (post-pop) last valid slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
            end
            if (w_push) r_mem[w_wr_idx] <= i_dat;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(i_push && !i_clear && !w_pop && o_full));

endmodule

// File: rtl/j1_fetch.sv
// J1 fetch stage: drives rom8kx16, tags returning words with their PC, queues them.
// Latency: issue in cycle t, word pushed at end of t+1, insn_valid in t+2.
// Backpressure: issue stops once queued + in-flight words reach DEPTH.
module j1_fetch
    import j1_pkg::*;
#(
    parameter int                    ADDR_WIDTH = J1_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = J1_DATA_WIDTH,
    parameter int                    DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic      clock,
    input  logic      reset_n,
    j1_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;

    logic                  w_redirect;
    logic                  w_pop;
    logic                  w_kill;
    logic                  w_push;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_rom_address;
    logic [OW-1:0]         w_occ;
    logic [CW-1:0]         w_count;
    logic                  w_empty;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_rom_q;
    fetch_entry_t          w_entry;
    fetch_entry_t          w_head;

    // Redirect is ignored while reset is held so the ROM pins stay quiet.
    assign w_redirect = reset_n & bus.redirect;

    // A head offered in a redirect cycle is void: the decoder drops it and
    // the queue is cleared, so it must not count as consumed here either.
    assign w_pop = bus.insn_valid & bus.insn_ready & ~w_redirect;

    // The ROM is single-cycle, so the only read that can be outstanding at a
    // redirect is the one returning right now; it is killed in that cycle.
    assign w_kill = w_redirect & r_inflight;
    assign w_push = r_inflight & ~w_kill;

    // Words already owned (queued + returning) after this cycle's pop.
    assign w_occ = OW'(w_count) + OW'(r_inflight) - OW'(w_pop);

    // Gating with reset_n lets the first read go out in the very cycle reset
    // is released, and silences the ROM immediately when reset asserts.
    assign w_issue       = reset_n & (w_redirect | (w_occ < OW'(DEPTH)));
    assign w_rom_address = w_redirect ? bus.redirect_pc : r_fetch_pc;

    assign bus.rom_cen     = w_issue;
    assign bus.rom_address = w_rom_address;

    assign w_rom_q    = bus.rom_q;
    assign w_entry.pc   = r_inflight_pc;
    assign w_entry.insn = w_rom_q;

    assign bus.insn_valid = ~w_empty;
    assign bus.insn       = w_head.insn;
    assign bus.insn_pc    = w_head.pc;

    // PC tracking: every issue advances fetch_pc past the address just read,
    // which also makes a redirect restart at target+1 (wrapping naturally).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= w_rom_address;
                r_fetch_pc    <= w_rom_address + ADDR_WIDTH'(1);
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_redirect),
        .i_dat   (w_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Issue throttling guarantees a full queue never has a read in flight.
    a_no_full_inflight: assert property (@(posedge clock) disable iff (!reset_n)
        !(w_full && r_inflight));

endmodule
